// File: rtl/config_bitstream_loader.sv
`default_nettype none
// ============================================================================
// Module   : config_bitstream_loader
// Brief    : Serial configuration port. Hunts for a sync word, assembles
//            NUM_WORDS 32-bit words with write strobes, validates an XOR checksum.
// Revision : 1.0  initial release
// ============================================================================
module config_bitstream_loader #(
    parameter int          NUM_WORDS = 57,
    parameter int          ADDR_W    = 6,
    parameter logic [31:0] SYNC_WORD = 32'hA5C30F5A
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic              cfg_we,
    output logic [ADDR_W-1:0] cfg_addr,
    output logic [31:0]       cfg_data,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC  = 3'd1,
        LOAD  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       shreg_q, shreg_d;
    logic [4:0]        bitcnt_q, bitcnt_d;
    logic [ADDR_W-1:0] wordcnt_q, wordcnt_d;
    logic [31:0]       csum_q, csum_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic [31:0]       w_shift;
    logic              w_word_end;

    assign w_shift    = {shreg_q[30:0], bit_in};
    assign w_word_end = (bitcnt_q == 5'd31);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            wordcnt_q <= '0;
            csum_q    <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            wordcnt_q <= wordcnt_d;
            csum_q    <= csum_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        wordcnt_d = wordcnt_q;
        csum_d    = csum_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        done_d    = done_q;
        error_d   = error_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d   = SYNC;
                    shreg_d   = '0;
                    bitcnt_d  = '0;
                    wordcnt_d = '0;
                    csum_d    = '0;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                end
            end
            SYNC: begin
                if (bit_valid) begin
                    shreg_d = w_shift;
                    if (w_shift == SYNC_WORD) begin
                        state_d  = LOAD;
                        bitcnt_d = '0;
                    end
                end
            end
            LOAD: begin
                if (bit_valid) begin
                    shreg_d  = w_shift;
                    bitcnt_d = bitcnt_q + 5'd1;
                    if (w_word_end) begin
                        we_d   = 1'b1;
                        addr_d = wordcnt_q;
                        data_d = w_shift;
                        csum_d = csum_q ^ w_shift;
                        // Leave LOAD on the last word so the word counter never wraps
                        if (wordcnt_q == LAST_WORD) begin
                            state_d = CHECK;
                        end else begin
                            wordcnt_d = wordcnt_q + 1'b1;
                        end
                    end
                end
            end
            CHECK: begin
                if (bit_valid) begin
                    shreg_d  = w_shift;
                    bitcnt_d = bitcnt_q + 5'd1;
                    if (w_word_end) begin
                        if (w_shift == csum_q) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ERR;
                            error_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cfg_we   = we_q;
    assign cfg_addr = addr_q;
    assign cfg_data = data_q;
    assign done     = done_q;
    assign error    = error_q;
    assign busy     = (state_q == SYNC) || (state_q == LOAD) || (state_q == CHECK);

endmodule
`default_nettype wire

// File: tb/tb_config_bitstream_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_config_bitstream_loader
// Brief    : Randomized self-checking bench against a stream-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_config_bitstream_loader;

    localparam int          NW   = 57;
    localparam logic [31:0] SYNC = 32'hA5C30F5A;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        cfg_we;
    logic [5:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        busy;
    logic        done;
    logic        error;

    config_bitstream_loader #(.NUM_WORDS(NW), .ADDR_W(6), .SYNC_WORD(SYNC)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          a;
        logic [31:0] d;
        int          c;
    } wr_t;

    wr_t caps[$];
    wr_t mon_w;
    always @(negedge clock) begin
        if (cfg_we === 1'b1) begin
            mon_w.a = int'(cfg_addr);
            mon_w.d = cfg_data;
            mon_w.c = cyc;
            caps.push_back(mon_w);
        end
    end

    logic        stream[$];
    int          tstamp[$];
    logic [31:0] words[NW];
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge. gap<0 picks a random gap 0..3.
    task automatic send_bit(input logic b, input int gap);
        int g;
        g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        bit_in    = b;
        bit_valid = 1'b1;
        stream.push_back(b);
        tstamp.push_back(cyc);
        @(negedge clock);
        if (g > 0) begin
            bit_valid = 1'b0;
            repeat (g) @(negedge clock);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 31; i >= 0; i--) send_bit(w[i], gap);
    endtask

    task automatic pulse_start();
        bit_valid = 1'b0;
        start     = 1'b1;
        @(negedge clock);
        start     = 1'b0;
    endtask

    function automatic logic [31:0] slice(input int from);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 32; i++) v = {v[30:0], stream[from + i]};
        return v;
    endfunction

    // Reference model: locate the preamble in the recorded stream, derive every
    // expected write (address, word, strobe cycle) and the final verdict.
    task automatic check_stream(input string tag, output bit exp_done, output bit exp_err);
        int          p;
        int          avail;
        int          nw;
        logic [31:0] x;
        p = -1;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        for (int i = 31; i < stream.size(); i++) begin
            if (slice(i - 31) == SYNC) begin
                p = i;
                break;
            end
        end
        chk({tag, "_sync_found"}, 64'(p >= 0), 64'd1);
        if (p < 0) return;
        avail = (stream.size() - 1 - p) / 32;
        nw    = (avail < NW) ? avail : NW;
        chk({tag, "_nwrites"}, 64'(caps.size()), 64'(nw));
        x = '0;
        for (int k = 0; k < nw; k++) begin
            x = x ^ slice(p + 1 + 32 * k);
            if (k < caps.size()) begin
                chk($sformatf("%s_addr%0d", tag, k), 64'(caps[k].a), 64'(k));
                chk($sformatf("%s_data%0d", tag, k), 64'(caps[k].d), 64'(slice(p + 1 + 32 * k)));
                chk($sformatf("%s_cyc%0d", tag, k), 64'(caps[k].c), 64'(tstamp[p + 32 * k + 32] + 1));
            end
        end
        if (avail > NW) begin
            exp_done = (slice(p + 1 + 32 * NW) == x);
            exp_err  = !exp_done;
        end
    endtask

    task automatic run_load(input string tag, input logic [31:0] cs, input int gap,
                            input int poke, input logic [7:0] junk, input int njunk);
        bit ed, ee;
        stream.delete();
        tstamp.delete();
        caps.delete();
        pulse_start();
        for (int i = njunk - 1; i >= 0; i--) send_bit(junk[i], gap);
        send_word(SYNC, gap);
        for (int k = 0; k < NW; k++) begin
            for (int i = 31; i >= 0; i--) begin
                if (k == poke && i == 15) start = 1'b1;
                send_bit(words[k][i], gap);
                start = 1'b0;
            end
        end
        for (int i = 31; i >= 1; i--) send_bit(cs[i], gap);
        send_bit(cs[0], 0);
        check_stream(tag, ed, ee);
        chk({tag, "_done_n1"}, 64'(done), 64'(ed));
        chk({tag, "_err_n1"}, 64'(error), 64'(ee));
        chk({tag, "_busy_n1"}, 64'(busy), 64'd0);
        bit_valid = 1'b0;
        repeat (4) @(negedge clock);
        chk({tag, "_done_hold"}, 64'(done), 64'(ed));
        chk({tag, "_err_hold"}, 64'(error), 64'(ee));
        chk({tag, "_excl"}, 64'(done & error), 64'd0);
        chk({tag, "_nwrites_hold"}, 64'(caps.size()), 64'(NW));
    endtask

    function automatic logic [31:0] xor_words();
        logic [31:0] x;
        x = '0;
        for (int k = 0; k < NW; k++) x = x ^ words[k];
        return x;
    endfunction

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_we", 64'(cfg_we), 64'd0);
        chk("rst_addr", 64'(cfg_addr), 64'd0);
        chk("rst_data", 64'(cfg_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(error), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // Asynchronous reset in the middle of word 10
        caps.delete();
        pulse_start();
        send_word(SYNC, 0);
        for (int k = 0; k < 10; k++) send_word(32'(k * 3 + 1), 0);
        for (int i = 0; i < 16; i++) send_bit(i[0], 0);
        chk("mid_nwrites", 64'(caps.size()), 64'd10);
        chk("mid_busy", 64'(busy), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_we", 64'(cfg_we), 64'd0);
        chk("arst_addr", 64'(cfg_addr), 64'd0);
        chk("arst_data", 64'(cfg_data), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_err", 64'(error), 64'd0);
        bit_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        caps.delete();
        send_word(SYNC, 0);
        for (int k = 0; k < 3; k++) send_word(32'h12345678, 0);
        bit_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("arst_nowrites", 64'(caps.size()), 64'd0);
        chk("arst_idle", 64'(busy), 64'd0);

        // Good and bad checksum with all-ones payload
        for (int k = 0; k < NW; k++) words[k] = 32'hFFFFFFFF;
        run_load("good", 32'hFFFFFFFF, 0, -1, 8'b10110, 5);
        run_load("badcs", 32'h0, 0, -1, 8'b10110, 5);

        // Gapped stream, word k carries k
        for (int k = 0; k < NW; k++) words[k] = 32'(k);
        run_load("gap3", xor_words(), 2, -1, 8'h00, 0);

        // Start mid-load is ignored; start in DONE restarts
        for (int k = 0; k < NW; k++) words[k] = $urandom;
        run_load("poke", xor_words(), 0, 20, 8'h3, 2);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("restart_done", 64'(done), 64'd0);
        chk("restart_busy", 64'(busy), 64'd1);

        for (int r = 0; r < 3; r++) begin
            logic [31:0] cs;
            for (int k = 0; k < NW; k++) words[k] = $urandom;
            cs = (r == 1) ? xor_words() ^ (32'h1 << $urandom_range(0, 31)) : xor_words();
            run_load($sformatf("rnd%0d", r), cs, -1, -1, 8'($urandom_range(0, 255)),
                     int'($urandom_range(0, 8)));
        end

        // Alternating bits never form the preamble
        caps.delete();
        stream.delete();
        tstamp.delete();
        pulse_start();
        for (int i = 0; i < 1000; i++) send_bit(i[0], 0);
        bit_valid = 1'b0;
        @(negedge clock);
        chk("nosync_busy", 64'(busy), 64'd1);
        chk("nosync_writes", 64'(caps.size()), 64'd0);
        chk("nosync_done", 64'(done | error), 64'd0);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
